// File: rtl/da_shift_accumulator.sv
// Distributed-arithmetic shift-accumulator: sums one ROM partial-sum word
// per bit cycle (LSB first), subtracts the sign-bit term, emits y per frame.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active-low
//   en       clock enable
//   start    frame start, rom_data carries R_0 in this cycle
//   rom_data signed ROM partial sum R_b for the current bit cycle
//   ts       high during the sign-bit cycle
//   busy     frame in progress
//   y        signed result of the last completed frame
//   y_valid  one-cycle pulse when y updates
module da_shift_accumulator #(
  parameter int word_width = 16,
  parameter int acc_width  = 34,
  parameter logic signed [word_width-1:0] Q0_initial = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        start,
  input  logic signed [word_width-1:0] rom_data,
  output logic                        ts,
  output logic                        busy,
  output logic signed [acc_width-1:0] y,
  output logic                        y_valid
);

  localparam int CW = $clog2(word_width);
  localparam logic [CW-1:0] LAST = CW'(word_width - 1);
  localparam int XW = acc_width - word_width;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                      r_state;
  logic [CW-1:0]               r_cnt;
  logic signed [acc_width-1:0] r_acc;
  logic signed [acc_width-1:0] r_y;
  logic                        r_yv;

  logic signed [acc_width-1:0] w_ext;
  logic signed [acc_width-1:0] w_q0;
  logic signed [acc_width-1:0] w_term;
  logic signed [acc_width-1:0] w_sum;
  logic signed [acc_width-1:0] w_dif;

  assign w_ext  = {{XW{rom_data[word_width-1]}}, rom_data};
  assign w_q0   = {{XW{Q0_initial[word_width-1]}}, Q0_initial};
  // Weight R_b by 2^b; the shift drops bits above acc_width (mod wrap).
  assign w_term = w_ext << r_cnt;
  assign w_sum  = r_acc + w_term;
  assign w_dif  = r_acc - w_term;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      r_yv    <= 1'b0;
    end else if (en) begin
      r_yv <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_acc   <= w_q0 + w_ext;
            r_cnt   <= CW'(1);
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (r_cnt == LAST) begin
            // Sign-bit term carries negative weight.
            r_acc   <= w_dif;
            r_y     <= w_dif;
            r_yv    <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = (r_state == ACCUM);
  assign ts      = (r_state == ACCUM) && (r_cnt == LAST);
  assign y       = r_y;
  assign y_valid = r_yv;

endmodule
